// File: rtl/burst_sum_pkg.sv
// -----------------------------------------------------------------------------
// burst_sum_pkg
// Shared types and elaboration-time helpers for the burst-sum sequencer.
//   state_t   : sequencer FSM states (IDLE -> RUN -> WAIT -> OUT -> IDLE)
//   clog2_f   : ceil(log2(value)), never below 1 so it is always usable as a width
//   sum_width : width of a WIN-sample unsigned sum of DATA_W-bit samples
// -----------------------------------------------------------------------------
package burst_sum_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2,
        OUT  = 2'd3
    } state_t;

    function automatic int clog2_f(input int value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

    // WIN is a power of two, so WIN samples of the maximum value fit exactly.
    function automatic int sum_width(input int data_w, input int win);
        return data_w + clog2_f(win);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin picker. The winner is the lowest requesting index
// at or above i_ptr, wrapping past N_REQ-1 back to 0.
// Ports:
//   i_req     in  N_REQ  request vector
//   i_ptr     in  ID_W   index with highest priority this round
//   o_gnt_oh  out N_REQ  one-hot grant (zero when no request)
//   o_gnt_idx out ID_W   encoded grant index (0 when no request)
//   o_any     out 1      at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter
    import burst_sum_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = clog2_f(N_REQ)
)(
    input  logic [N_REQ-1:0] i_req,
    input  logic [ID_W-1:0]  i_ptr,
    output logic [N_REQ-1:0] o_gnt_oh,
    output logic [ID_W-1:0]  o_gnt_idx,
    output logic             o_any
);

    always_comb begin
        int   w_idx;
        logic w_found;
        w_idx     = 0;
        w_found   = 1'b0;
        o_gnt_oh  = '0;
        o_gnt_idx = '0;
        // Scan N_REQ positions starting at the pointer; first hit wins.
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = (int'(i_ptr) + k) % N_REQ;
            if (!w_found && i_req[w_idx]) begin
                w_found          = 1'b1;
                o_gnt_oh[w_idx]  = 1'b1;
                o_gnt_idx        = ID_W'(w_idx);
            end
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/burst_sum_sched.sv
// -----------------------------------------------------------------------------
// burst_sum_sched
// Arbitrating sequencer for a shared windowed-sum datapath. Grants the datapath
// to one requester per burst of WIN samples (round-robin), clears and strobes
// the external accumulator, then returns the sum tagged with the requester ID.
//
// Optional feature macro: BURST_TIMEOUT_EN
//   defined   : a stalled burst (granted lane idle for TIMEOUT consecutive
//               cycles) is aborted and reported with res_err=1, res_sum=0.
//   undefined : bursts wait indefinitely, res_err is tied to 0.
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   req_valid  : per-requester sample valid            (N_REQ)
//   req_data   : packed samples, lane i at [i*DATA_W +: DATA_W]
//   req_ready  : one-hot (or zero) sample accept       (N_REQ)
//   dp_clr     : accumulator clear pulse (grant cycle)
//   dp_en      : accumulate strobe (granted handshake)
//   dp_data    : sample to the datapath
//   dp_sum     : accumulator output, valid 1 cycle after last dp_en
//   res_valid/res_ready : result handshake
//   res_sum, res_id, res_err : result payload
// -----------------------------------------------------------------------------
module burst_sum_sched
    import burst_sum_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = 8,
    parameter int WIN     = 8,
    parameter int SUM_W   = sum_width(DATA_W, WIN),
    parameter int TIMEOUT = 16
)(
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [N_REQ*DATA_W-1:0]       req_data,
    output logic [N_REQ-1:0]              req_ready,
    output logic                          dp_clr,
    output logic                          dp_en,
    output logic [DATA_W-1:0]             dp_data,
    input  logic [SUM_W-1:0]              dp_sum,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [SUM_W-1:0]              res_sum,
    output logic [clog2_f(N_REQ)-1:0]     res_id,
    output logic                          res_err
);

    localparam int ID_W  = clog2_f(N_REQ);
    localparam int CNT_W = clog2_f(WIN);

    state_t             r_state;
    state_t             w_next;
    logic [ID_W-1:0]    r_rr_ptr;
    logic [ID_W-1:0]    r_gnt;
    logic [N_REQ-1:0]   r_gnt_oh;
    logic [CNT_W-1:0]   r_cnt;
    logic [SUM_W-1:0]   r_res_sum;
    logic [ID_W-1:0]    r_res_id;

    logic [N_REQ-1:0]   w_arb_oh;
    logic [ID_W-1:0]    w_arb_idx;
    logic               w_arb_any;
    logic               w_gnt_valid;
    logic               w_accept;
    logic [DATA_W-1:0]  w_lane [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_lane
        assign w_lane[g] = req_data[g*DATA_W +: DATA_W];
    end

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .i_req     (req_valid),
        .i_ptr     (r_rr_ptr),
        .o_gnt_oh  (w_arb_oh),
        .o_gnt_idx (w_arb_idx),
        .o_any     (w_arb_any)
    );

    assign w_gnt_valid = req_valid[r_gnt];
    assign w_accept    = (r_state == RUN) && w_gnt_valid;

`ifdef BURST_TIMEOUT_EN
    localparam int STALL_W = clog2_f(TIMEOUT + 1);

    logic [STALL_W-1:0] r_stall;
    logic               r_res_err;
    logic               w_abort;

    // Abort on the TIMEOUT-th consecutive idle cycle of the granted lane.
    assign w_abort = (r_state == RUN) && !w_gnt_valid &&
                     (r_stall == STALL_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall   <= '0;
            r_res_err <= 1'b0;
        end else begin
            if ((r_state == RUN) && !w_accept)
                r_stall <= r_stall + STALL_W'(1);
            else
                r_stall <= '0;

            if (r_state == WAIT)
                r_res_err <= 1'b0;
            else if (w_abort)
                r_res_err <= 1'b1;
        end
    end

    assign res_err = r_res_err;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT > 0);
    assign res_err          = 1'b0;
`endif

    always_comb begin
        w_next    = r_state;
        req_ready = '0;
        dp_clr    = 1'b0;
        dp_en     = 1'b0;
        dp_data   = '0;
        res_valid = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (w_arb_any) begin
                    dp_clr = 1'b1;
                    w_next = RUN;
                end
            end
            RUN: begin
                // Granted lane only; other requesters wait for the next round.
                req_ready = r_gnt_oh;
                if (w_gnt_valid) begin
                    dp_en   = 1'b1;
                    dp_data = w_lane[r_gnt];
                    if (r_cnt == CNT_W'(WIN - 1))
                        w_next = WAIT;
                end
`ifdef BURST_TIMEOUT_EN
                else if (w_abort) begin
                    w_next = OUT;
                end
`endif
            end
            WAIT: begin
                w_next = OUT;
            end
            OUT: begin
                res_valid = 1'b1;
                if (res_ready)
                    w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase

        // Keep every strobe quiet while reset is held, even if requests are up.
        if (rst) begin
            req_ready = '0;
            dp_clr    = 1'b0;
            dp_en     = 1'b0;
            dp_data   = '0;
            res_valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_rr_ptr  <= '0;
            r_gnt     <= '0;
            r_gnt_oh  <= '0;
            r_cnt     <= '0;
            r_res_sum <= '0;
            r_res_id  <= '0;
        end else begin
            r_state <= w_next;
            unique case (r_state)
                IDLE: begin
                    if (w_arb_any) begin
                        r_gnt    <= w_arb_idx;
                        r_gnt_oh <= w_arb_oh;
                        r_cnt    <= '0;
                    end
                end
                RUN: begin
                    if (w_accept)
                        r_cnt <= r_cnt + CNT_W'(1);
                end
                WAIT: begin
                    r_res_sum <= dp_sum;
                    r_res_id  <= r_gnt;
                end
                OUT: begin
                    // Just-served requester drops to lowest priority.
                    if (res_ready)
                        r_rr_ptr <= (r_gnt == ID_W'(N_REQ - 1)) ? '0 : r_gnt + ID_W'(1);
                end
                default: ;
            endcase
`ifdef BURST_TIMEOUT_EN
            if (w_abort) begin
                r_res_sum <= '0;
                r_res_id  <= r_gnt;
            end
`endif
        end
    end

    assign res_sum = r_res_sum;
    assign res_id  = r_res_id;

endmodule

// File: tb/tb_burst_sum_sched.sv
module tb_burst_sum_sched;

    localparam int N_REQ   = 4;
    localparam int DATA_W  = 8;
    localparam int WIN     = 8;
    localparam int SUM_W   = 11;
    localparam int TIMEOUT = 16;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic                    dp_clr;
    logic                    dp_en;
    logic [DATA_W-1:0]       dp_data;
    logic [SUM_W-1:0]        dp_sum;
    logic                    res_valid;
    logic                    res_ready;
    logic [SUM_W-1:0]        res_sum;
    logic [1:0]              res_id;
    logic                    res_err;

    int checks = 0;
    int errors = 0;
    int n_clr  = 0;
    int n_en   = 0;
    int c0, e0, n;
    bit got;

    always #5 clk = ~clk;

    burst_sum_sched #(
        .N_REQ   (N_REQ),
        .DATA_W  (DATA_W),
        .WIN     (WIN),
        .SUM_W   (SUM_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .dp_clr    (dp_clr),
        .dp_en     (dp_en),
        .dp_data   (dp_data),
        .dp_sum    (dp_sum),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_id    (res_id),
        .res_err   (res_err)
    );

    // External sum engine: clear on dp_clr, accumulate on dp_en.
    logic [SUM_W-1:0] acc;
    always_ff @(posedge clk) begin
        if (dp_clr)     acc <= '0;
        else if (dp_en) acc <= acc + SUM_W'(dp_data);
    end
    assign dp_sum = acc;

    always @(posedge clk) begin
        if (dp_clr) n_clr <= n_clr + 1;
        if (dp_en)  n_en  <= n_en + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_lane(input int id, input int v);
        req_data[id*DATA_W +: DATA_W] = DATA_W'(v);
    endtask

    // Full burst from IDLE: grant cycle, WIN accepts, WAIT, OUT.
    task automatic do_burst(input int id, input int base, input int step,
                            input int exp_sum, input bit keep);
        req_valid[id] = 1'b1;
        set_lane(id, base);
        #1;
        chk("idle_dp_clr", dp_clr, 1);
        chk("idle_req_ready", req_ready, 0);
        cyc();
        for (int k = 0; k < WIN; k++) begin
            set_lane(id, base + k*step);
            #1;
            chk("run_req_ready", req_ready, 32'(1) << id);
            chk("run_dp_en", dp_en, 1);
            chk("run_dp_data", dp_data, base + k*step);
            cyc();
        end
        if (!keep) req_valid[id] = 1'b0;
        #1;
        chk("wait_res_valid", res_valid, 0);
        chk("wait_req_ready", req_ready, 0);
        cyc();
        #1;
        chk("out_res_valid", res_valid, 1);
        chk("out_res_sum", res_sum, exp_sum);
        chk("out_res_id", res_id, id);
        chk("out_res_err", res_err, 0);
        cyc();
    endtask

    // Burst of constant value with a stall of gap cycles after pre samples.
    task automatic stall_burst(input int id, input int val, input int pre, input int gap);
        req_valid[id] = 1'b1;
        set_lane(id, val);
        #1;
        chk("st_dp_clr", dp_clr, 1);
        cyc();
        for (int k = 0; k < pre; k++) begin
            #1; chk("st_pre_dp_en", dp_en, 1); cyc();
        end
        req_valid[id] = 1'b0;
        for (int k = 0; k < gap; k++) begin
            #1;
            chk("st_gap_dp_en", dp_en, 0);
            chk("st_gap_req_ready", req_ready, 32'(1) << id);
            chk("st_gap_res_valid", res_valid, 0);
            cyc();
        end
        req_valid[id] = 1'b1;
        for (int k = pre; k < WIN; k++) begin
            #1; chk("st_post_dp_en", dp_en, 1); cyc();
        end
        req_valid[id] = 1'b0;
        #1; chk("st_wait_res_valid", res_valid, 0); cyc();
        #1;
        chk("st_res_valid", res_valid, 1);
        chk("st_res_sum", res_sum, val * WIN);
        chk("st_res_id", res_id, id);
        chk("st_res_err", res_err, 0);
        cyc();
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        res_ready = 1'b1;
        @(negedge clk);
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_dp_clr", dp_clr, 0);
        chk("rst_dp_en", dp_en, 0);
        chk("rst_dp_data", dp_data, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_sum", res_sum, 0);
        chk("rst_res_id", res_id, 0);
        chk("rst_res_err", res_err, 0);
        cyc();

        // Requester 0 sends 1..8.
        c0 = n_clr;
        e0 = n_en;
        do_burst(0, 1, 1, 36, 1'b0);
        chk("s1_clr_count", n_clr - c0, 1);
        chk("s1_en_count", n_en - e0, WIN);

        // Requester 2 sends eight 255.
        do_burst(2, 255, 0, 2040, 1'b0);

        // Reset, then requesters 0,1,3 held valid: order 0,1,3,0,1,3.
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        req_valid = 4'b1011;
        set_lane(0, 1);
        set_lane(1, 2);
        set_lane(3, 3);
        for (int r = 0; r < 6; r++) begin
            int id;
            id = (r % 3 == 2) ? 3 : (r % 3);
            do_burst(id, (id == 3) ? 3 : id + 1, 0, ((id == 3) ? 3 : id + 1) * WIN, 1'b1);
        end
        req_valid = '0;

        // Requester 1, all 10, 5-cycle stall after sample 3.
        stall_burst(1, 10, 3, 5);

        // Requester 1, 20-cycle stall after sample 3.
`ifdef BURST_TIMEOUT_EN
        req_valid[1] = 1'b1;
        set_lane(1, 10);
        #1; chk("to_dp_clr", dp_clr, 1); cyc();
        for (int k = 0; k < 3; k++) begin
            #1; chk("to_pre_dp_en", dp_en, 1); cyc();
        end
        req_valid[1] = 1'b0;
        n   = 0;
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            #1;
            if (res_valid) got = 1'b1;
            else begin n++; cyc(); end
        end
        chk("to_res_valid", got, 1);
        chk("to_latency", n, TIMEOUT);
        chk("to_res_err", res_err, 1);
        chk("to_res_sum", res_sum, 0);
        chk("to_res_id", res_id, 1);
        cyc();
`else
        stall_burst(1, 10, 3, 20);
`endif

        // Result held back for 10 cycles; requester 0 waiting meanwhile.
        res_ready = 1'b0;
        do_burst(3, 1, 1, 36, 1'b0);
        req_valid[0] = 1'b1;
        set_lane(0, 5);
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("hold_res_valid", res_valid, 1);
            chk("hold_res_sum", res_sum, 36);
            chk("hold_res_id", res_id, 3);
            chk("hold_req_ready", req_ready, 0);
            chk("hold_dp_clr", dp_clr, 0);
            cyc();
        end
        res_ready = 1'b1;
        #1; chk("hold_release_valid", res_valid, 1);
        cyc();
        do_burst(0, 5, 0, 40, 1'b0);

        // Reset after sample 4 of a burst from requester 1.
        req_valid[1] = 1'b1;
        set_lane(1, 1);
        #1; chk("mid_dp_clr", dp_clr, 1); cyc();
        for (int k = 0; k < 4; k++) begin
            #1; chk("mid_dp_en", dp_en, 1); cyc();
        end
        rst = 1'b1;
        cyc();
        #1;
        chk("mrst_req_ready", req_ready, 0);
        chk("mrst_dp_clr", dp_clr, 0);
        chk("mrst_dp_en", dp_en, 0);
        chk("mrst_dp_data", dp_data, 0);
        chk("mrst_res_valid", res_valid, 0);
        chk("mrst_res_sum", res_sum, 0);
        chk("mrst_res_id", res_id, 0);
        chk("mrst_res_err", res_err, 0);
        rst = 1'b0;
        req_valid = 4'b0011;
        set_lane(0, 1);
        do_burst(0, 1, 0, 8, 1'b0);
        req_valid = '0;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/burst_sum_sched.md
# burst_sum_sched

Arbitrating sequencer for the shared windowed-sum datapath. Up to N_REQ requesters each stream bursts of WIN samples; the block grants the datapath to one requester per burst (round-robin), clears and drives the accumulator, and returns the WIN-sample sum tagged with the requester ID. It sits between the sample sources and the sum engine, which has an 8-bit in / 11-bit out configuration by default.

## Interface
- N_REQ, 4, number of requesters (2..8)
- DATA_W, 8, sample width
- WIN, 8, samples per burst; power of two, ≥2
- SUM_W, DATA_W+$clog2(WIN) (=11), result width
- TIMEOUT, 16, stall limit in cycles (used only with BURST_TIMEOUT_EN)

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  N_REQ  per-requester sample valid
- req_data  in  N_REQ*DATA_W  packed samples; requester i at [i*DATA_W +: DATA_W]
- req_ready  out  N_REQ  one-hot (or zero) sample accept
- dp_clr  out  1  clear datapath accumulator
- dp_en  out  1  datapath accumulate strobe
- dp_data  out  DATA_W  sample to datapath
- dp_sum  in  SUM_W  datapath sum, valid 1 cycle after last dp_en
- res_valid  out  1  result available
- res_ready  in  1  result consumer accept
- res_sum  out  SUM_W  burst sum
- res_id  out  $clog2(N_REQ)  requester that owns res_sum
- res_err  out  1  burst aborted (0 unless BURST_TIMEOUT_EN)

## Operation
- FSM: IDLE → RUN → WAIT → OUT → IDLE.
- IDLE: if any req_valid, pick winner by round-robin from pointer rr_ptr (lowest index ≥ rr_ptr, wrapping); register gnt, pulse dp_clr for one cycle, cnt←0, go RUN. No req_valid: stay, all strobes 0.
- RUN: req_ready[gnt]=1, others 0. On req_valid[gnt]&req_ready[gnt]: dp_en=1, dp_data=sample, cnt++. Acceptance of sample WIN-1 (cnt==WIN-1) → WAIT. req_valid low: hold cnt and grant; no preemption by other requesters.
- WAIT: one cycle; capture dp_sum into res_sum, res_id←gnt, res_err←0 → OUT.
- OUT: res_valid=1 until res_valid&res_ready; then rr_ptr←(gnt+1) mod N_REQ, → IDLE. No new grant while result unconsumed.
- dp_data combinationally muxed from granted lane; dp_en = handshake of granted lane.
- Sum arithmetic unsigned; WIN samples of max value fit exactly in SUM_W, no overflow handling.

## Timing
- Reset: state IDLE, rr_ptr=0, cnt=0, req_ready=0, dp_clr=0, dp_en=0, dp_data=0, res_valid=0, res_sum=0, res_id=0, res_err=0.
- Grant to first accept: request seen in IDLE at cycle t; dp_clr at t; req_ready high from t+1.
- Back-to-back samples: one per cycle; minimum burst = WIN cycles in RUN.
- Last accept at t → dp_sum valid t+1 (WAIT) → res_valid at t+2.
- Min request-to-request period for one requester: WIN+3 cycles (with res_ready held high).
- rst mid-burst or with result pending: everything returns to reset values next edge; partial burst and pending result discarded.
- Simultaneous req_valid: winner strictly by rr_ptr order; requester that just finished has lowest priority.

## Configuration
- BURST_TIMEOUT_EN defined: stall counter in RUN counts consecutive cycles with req_valid[gnt]=0; at TIMEOUT, abort → OUT with res_err=1, res_sum=0, res_id=gnt; rr_ptr advances as normal. Counter clears on every accepted sample.
- Undefined: no counter, res_err tied 0, RUN waits indefinitely.

## Structure
- Package burst_sum_pkg: FSM state enum (IDLE, RUN, WAIT, OUT), clog2 helper, SUM_W derivation function.
- One sub-module: rr_arbiter (N_REQ request vector, rr_ptr in → one-hot grant + encoded index, combinational).
- Counter, FSM, result register, timeout logic in top.

## Test plan
- Requester 0 sends 1..8 back-to-back, res_ready=1 → dp_clr once, 8 dp_en, res_valid 2 cycles after last accept, res_sum=36, res_id=0.
- Requester 2 sends eight 255 → res_sum=2040, no overflow, res_id=2.
- Requesters 0,1,3 all valid continuously → result order ids 0,1,3,0,1,3; no grant change mid-burst.
- Requester 1 drops valid for 5 cycles after sample 3, values all 10 → cnt holds, res_sum=80; with BURST_TIMEOUT_EN and 20-cycle gap → res_err=1, res_sum=0.
- res_ready low for 10 cycles after result → res_valid/res_sum stable, req_ready all 0, no dp_clr until accepted.
- rst pulsed after sample 4 → all outputs reset next cycle; fresh burst of 8×1 then yields res_sum=8, res_id per rr_ptr=0.
